// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command pin encodings, mode-register fields,
// error-bit positions and the responder state type. Used by both the SDRAM
// controller and the sdram16_responder device model.
package sdram_pkg;

  // Command encodings on {cs_n, ras_n, cas_n, we_n}; DESL stands for any cs_n=1.
  typedef enum logic [3:0] {
    CMD_MRS   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_NOP   = 4'b0111,
    CMD_DESL  = 4'b1111
  } sdram_cmd_t;

  // Mode register fields carried on the address pins during MRS
  localparam int MODE_BL_LSB = 0;
  localparam int MODE_CL_LSB = 4;
  localparam int A10_BIT     = 10;

  // Sticky error-code bit positions
  localparam int ERR_CLOSED_BANK = 0;
  localparam int ERR_NO_MRS      = 1;
  localparam int ERR_ACT_OPEN    = 2;
  localparam int ERR_TIMING      = 3;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_RDLAT, ST_READ, ST_WRITE
  } resp_state_t;

  // Pin decode; the unused 0110 (burst stop) code is treated as a NOP.
  function automatic sdram_cmd_t decode_cmd(input logic cs_n, input logic ras_n,
                                            input logic cas_n, input logic we_n);
    sdram_cmd_t c;
    if (cs_n) c = CMD_DESL;
    else begin
      case ({ras_n, cas_n, we_n})
        3'b000:  c = CMD_MRS;
        3'b001:  c = CMD_REF;
        3'b010:  c = CMD_PRE;
        3'b011:  c = CMD_ACT;
        3'b100:  c = CMD_WRITE;
        3'b101:  c = CMD_READ;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

  // CAS latency field: only 3 is honoured, everything else runs as 2.
  function automatic logic [1:0] mode_cl(input logic [2:0] f);
    return (f == 3'd3) ? 2'd3 : 2'd2;
  endfunction

  // Burst length field as a column wrap mask (BL-1); unsupported codes give BL1.
  function automatic logic [2:0] mode_bl_mask(input logic [2:0] f);
    logic [2:0] m;
    case (f)
      3'd1:    m = 3'd1;
      3'd2:    m = 3'd3;
      3'd3:    m = 3'd7;
      default: m = 3'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sdram16_resp_mem.sv
// Word-wide RAM behind the SDRAM responder: one 8-bit array per byte lane so
// each lane maps to its own block RAM with a registered read.
module sdram16_resp_mem #(
  parameter int AW = 14
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [1:0]    be_i,
  input  logic [15:0]   wdata_i,
  input  logic          re_i,
  output logic [15:0]   rdata_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] r_mem [2**AW];
      logic [7:0] r_q;

      // Byte-lane write and registered read
      always_ff @(posedge clk_i) begin
        if (we_i && be_i[gi]) r_mem[addr_i] <= wdata_i[gi*8 +: 8];
        if (re_i) r_q <= r_mem[addr_i];
      end

      assign rdata_o[gi*8 +: 8] = r_q;
    end
  endgenerate

endmodule

// File: rtl/sdram16_responder.sv
// 16-bit SDR SDRAM device model: decodes the command pins, tracks open rows per
// bank and serves wrapped read/write bursts from sdram16_resp_mem.
// Optional macro SDRAM16_RESP_TCHK_EN compiles in tRCD/tRP/tRFC checking.
module sdram16_responder
  import sdram_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 10,
  parameter int TRCD   = 2,
  parameter int TRP    = 2,
  parameter int TRFC   = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cke_i,
  input  logic        cs_n_i,
  input  logic        ras_n_i,
  input  logic        cas_n_i,
  input  logic        we_n_i,
  input  logic [1:0]  ba_i,
  input  logic [12:0] addr_i,
  input  logic [1:0]  dqm_i,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dq_oe_o,
  output logic        err_o,
  output logic [3:0]  err_code_o,
  output logic [15:0] ref_cnt_o
);

  resp_state_t       r_state;
  logic [1:0]        r_cl;
  logic [2:0]        r_bl_mask;
  logic [1:0]        r_lat_cnt;
  logic [3:0]        r_left;
  logic [1:0]        r_bank;
  logic [MEM_AW-COL_W-1:0] r_page;
  logic [COL_W-1:0]  r_col;
  logic              r_ap;
  logic              r_oe;
  logic              r_err;
  logic [3:0]        r_err_code;
  logic [15:0]       r_ref_cnt;
  logic [3:0]        r_open;
  logic [ROW_W-1:0]  r_row [4];

  sdram_cmd_t        w_cmd;
  logic              w_init, w_in_burst, w_rw, w_rw_ok, w_abort, w_wr_now;
  logic              w_rd_beat, w_wr_beat, w_burst_end, w_tviol;
  logic [COL_W-1:0]  w_cmd_col;
  logic [MEM_AW-1:0] w_cmd_waddr, w_mem_addr;
  logic [15:0]       w_rdata;
  logic [3:0]        w_err_ev, w_close;
  logic [3:0]        w_rd_len;

  // Next column inside the BL-aligned block (only the masked low bits advance)
  function automatic logic [COL_W-1:0] f_next_col(input logic [COL_W-1:0] c,
                                                  input logic [2:0] m);
    logic [COL_W-1:0] mm;
    mm = COL_W'(m);
    return (c & ~mm) | ((c + 1'b1) & mm);
  endfunction

  assign w_cmd       = decode_cmd(cs_n_i, ras_n_i, cas_n_i, we_n_i);
  assign w_init      = (r_state == ST_INIT);
  assign w_in_burst  = (r_state == ST_RDLAT) || (r_state == ST_READ) || (r_state == ST_WRITE);
  assign w_rw        = (w_cmd == CMD_READ) || (w_cmd == CMD_WRITE);
  assign w_rw_ok     = w_rw && !w_init && r_open[ba_i];
  // A new accepted column command or a mode change cuts the running burst short
  assign w_abort     = w_in_burst && (w_rw_ok || (w_cmd == CMD_MRS));
  assign w_wr_now    = w_rw_ok && (w_cmd == CMD_WRITE);
  assign w_rd_beat   = (r_state == ST_READ) && !w_abort;
  assign w_wr_beat   = (r_state == ST_WRITE) && !w_abort;
  assign w_burst_end = w_abort || ((w_rd_beat || w_wr_beat) && (r_left == 4'd1));
  assign w_rd_len    = {1'b0, r_bl_mask} + 4'd1;

  assign w_cmd_col   = addr_i[COL_W-1:0];
  assign w_cmd_waddr = MEM_AW'({ba_i, r_row[ba_i], w_cmd_col});
  // Beat 0 of a write lands on the command edge; all other beats use the burst registers
  assign w_mem_addr  = w_wr_now ? w_cmd_waddr : {r_page, r_col};

  sdram16_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk_i   (clk_i),
    .addr_i  (w_mem_addr),
    .we_i    (cke_i && (w_wr_now || w_wr_beat)),
    .be_i    (~dqm_i),
    .wdata_i (dq_i),
    .re_i    (cke_i && w_rd_beat),
    .rdata_o (w_rdata)
  );

  // Protocol error events raised by the command sampled this edge
  always_comb begin
    w_err_ev                  = '0;
    w_err_ev[ERR_NO_MRS]      = w_init && (w_rw || (w_cmd == CMD_ACT));
    w_err_ev[ERR_CLOSED_BANK] = !w_init && w_rw && !r_open[ba_i];
    w_err_ev[ERR_ACT_OPEN]    = !w_init && (w_cmd == CMD_ACT) && r_open[ba_i];
    w_err_ev[ERR_TIMING]      = w_tviol;
  end

`ifdef SDRAM16_RESP_TCHK_EN
  logic [7:0] r_trcd_cnt [4];
  logic [7:0] r_trp_cnt  [4];
  logic [7:0] r_trfc_cnt;

  assign w_tviol = (w_rw && (r_trcd_cnt[ba_i] != 8'd0))
                || ((w_cmd == CMD_ACT) && (r_trp_cnt[ba_i] != 8'd0))
                || ((w_cmd != CMD_NOP) && (w_cmd != CMD_DESL) && (r_trfc_cnt != 8'd0));

  // Down-counters of cycles still owed after ACT / PRE per bank and after REF
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        r_trcd_cnt[i] <= '0;
        r_trp_cnt[i]  <= '0;
      end
      r_trfc_cnt <= '0;
    end else if (cke_i) begin
      for (int i = 0; i < 4; i++) begin
        if ((w_cmd == CMD_ACT) && (ba_i == 2'(i))) r_trcd_cnt[i] <= 8'(TRCD - 1);
        else if (r_trcd_cnt[i] != 8'd0)            r_trcd_cnt[i] <= r_trcd_cnt[i] - 8'd1;
        if ((w_cmd == CMD_PRE) && (addr_i[A10_BIT] || (ba_i == 2'(i)))) r_trp_cnt[i] <= 8'(TRP - 1);
        else if (r_trp_cnt[i] != 8'd0)                                  r_trp_cnt[i] <= r_trp_cnt[i] - 8'd1;
      end
      if (w_cmd == CMD_REF)          r_trfc_cnt <= 8'(TRFC - 1);
      else if (r_trfc_cnt != 8'd0)   r_trfc_cnt <= r_trfc_cnt - 8'd1;
    end
  end
`else
  // Timing parameters only take effect with checking compiled in; constant false here
  assign w_tviol = (TRCD < 0) || (TRP < 0) || (TRFC < 0);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_close
      assign w_close[gi] = ((w_cmd == CMD_PRE) && (addr_i[A10_BIT] || (ba_i == 2'(gi))))
                        || (r_ap && w_burst_end && (r_bank == 2'(gi)))
                        || (w_wr_now && (r_bl_mask == 3'd0) && addr_i[A10_BIT] && (ba_i == 2'(gi)));
    end
  endgenerate

  // Per-bank open flag and row; a fresh ACT outranks a same-edge close
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_open <= '0;
      for (int i = 0; i < 4; i++) r_row[i] <= '0;
    end else if (cke_i) begin
      for (int i = 0; i < 4; i++) begin
        if ((w_cmd == CMD_ACT) && !w_init && (ba_i == 2'(i))) begin
          r_open[i] <= 1'b1;
          r_row[i]  <= addr_i[ROW_W-1:0];
        end else if (w_close[i]) begin
          r_open[i] <= 1'b0;
        end
      end
    end
  end

  // Command FSM, burst sequencing and registered status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_INIT;
      r_cl       <= 2'd2;
      r_bl_mask  <= '0;
      r_lat_cnt  <= '0;
      r_left     <= '0;
      r_bank     <= '0;
      r_page     <= '0;
      r_col      <= '0;
      r_ap       <= 1'b0;
      r_oe       <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
      r_ref_cnt  <= '0;
    end else if (cke_i) begin
      r_oe       <= w_rd_beat;
      r_err      <= |w_err_ev;
      r_err_code <= r_err_code | w_err_ev;
      if (w_cmd == CMD_REF) r_ref_cnt <= r_ref_cnt + 16'd1;
      if (w_cmd == CMD_MRS) begin
        r_cl      <= mode_cl(addr_i[MODE_CL_LSB +: 3]);
        r_bl_mask <= mode_bl_mask(addr_i[MODE_BL_LSB +: 3]);
        r_state   <= ST_IDLE;
      end else if (w_rw_ok) begin
        r_bank <= ba_i;
        r_page <= w_cmd_waddr[MEM_AW-1:COL_W];
        r_ap   <= addr_i[A10_BIT];
        if (w_cmd == CMD_READ) begin
          r_col     <= w_cmd_col;
          r_left    <= w_rd_len;
          r_lat_cnt <= r_cl - 2'd1;
          r_state   <= ST_RDLAT;
        end else begin
          r_col   <= f_next_col(w_cmd_col, r_bl_mask);
          r_left  <= {1'b0, r_bl_mask};
          r_state <= (r_bl_mask == 3'd0) ? ST_IDLE : ST_WRITE;
        end
      end else begin
        case (r_state)
          ST_RDLAT: begin
            if (r_lat_cnt <= 2'd1) r_state <= ST_READ;
            else                   r_lat_cnt <= r_lat_cnt - 2'd1;
          end
          ST_READ, ST_WRITE: begin
            r_col  <= f_next_col(r_col, r_bl_mask);
            r_left <= r_left - 4'd1;
            if (r_left <= 4'd1) r_state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // RAM read register holds the beat; forced to zero whenever not driving
  assign dq_o       = r_oe ? w_rdata : 16'h0000;
  assign dq_oe_o    = r_oe;
  assign err_o      = r_err;
  assign err_code_o = r_err_code;
  assign ref_cnt_o  = r_ref_cnt;

endmodule

// File: tb/tb_sdram16_responder.sv
// Directed bench for sdram16_responder: table of per-cycle commands with
// expected outputs, plus hand-written reset, refresh-wrap and reset-mid-burst
// sequences. Build with SDRAM16_RESP_TCHK_EN to exercise timing checking.
module tb_sdram16_responder;

`ifdef SDRAM16_RESP_TCHK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                         C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                         C_MRS = 4'b0000;

  logic        clk_i = 1'b0;
  logic        rst_i, cke_i, cs_n_i, ras_n_i, cas_n_i, we_n_i;
  logic [1:0]  ba_i, dqm_i;
  logic [12:0] addr_i;
  logic [15:0] dq_i;
  logic [15:0] dq_o;
  logic        dq_oe_o, err_o;
  logic [3:0]  err_code_o;
  logic [15:0] ref_cnt_o;

  sdram16_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i), .cs_n_i(cs_n_i), .ras_n_i(ras_n_i),
    .cas_n_i(cas_n_i), .we_n_i(we_n_i), .ba_i(ba_i), .addr_i(addr_i), .dqm_i(dqm_i),
    .dq_i(dq_i), .dq_o(dq_o), .dq_oe_o(dq_oe_o), .err_o(err_o),
    .err_code_o(err_code_o), .ref_cnt_o(ref_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] dq;
    logic        exp_oe;
    logic [15:0] exp_dq;
    logic        exp_err;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [1:0] dqm, input logic [15:0] dq);
    {cs_n_i, ras_n_i, cas_n_i, we_n_i} = cmd;
    ba_i = ba; addr_i = addr; dqm_i = dqm; dq_i = dq;
  endtask

  task automatic step(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                      input logic [1:0] dqm, input logic [15:0] dq);
    drive(cmd, ba, addr, dqm, dq);
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                     input logic [1:0] dqm, input logic [15:0] dq, input logic exp_oe,
                     input logic [15:0] exp_dq, input logic exp_err, input logic [3:0] exp_code);
    vec_t v;
    v.cmd = cmd; v.ba = ba; v.addr = addr; v.dqm = dqm; v.dq = dq;
    v.exp_oe = exp_oe; v.exp_dq = exp_dq; v.exp_err = exp_err; v.exp_code = exp_code;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cmd, vecs[i].ba, vecs[i].addr, vecs[i].dqm, vecs[i].dq);
      $display("%s[%0d] cmd=%b ba=%0d addr=%h dq_in=%h -> oe=%b dq=%h err=%b code=%b",
               tag, i, vecs[i].cmd, vecs[i].ba, vecs[i].addr, vecs[i].dq,
               dq_oe_o, dq_o, err_o, err_code_o);
      check($sformatf("%s[%0d] err_o", tag, i), 32'(err_o), 32'(vecs[i].exp_err));
      check($sformatf("%s[%0d] dq_oe_o", tag, i), 32'(dq_oe_o), 32'(vecs[i].exp_oe));
      check($sformatf("%s[%0d] err_code_o", tag, i), 32'(err_code_o), 32'(vecs[i].exp_code));
      if (vecs[i].exp_oe)
        check($sformatf("%s[%0d] dq_o", tag, i), 32'(dq_o), 32'(vecs[i].exp_dq));
    end
    vecs.delete();
  endtask

  initial begin
    logic [3:0] code_after_ref;

    rst_i = 1'b1; cke_i = 1'b1;
    drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    repeat (2) @(posedge clk_i);
    #1;
    check("reset dq_o", 32'(dq_o), 32'h0);
    check("reset dq_oe_o", 32'(dq_oe_o), 32'h0);
    check("reset err_o", 32'(err_o), 32'h0);
    check("reset err_code_o", 32'(err_code_o), 32'h0);
    check("reset ref_cnt_o", 32'(ref_cnt_o), 32'h0);
    rst_i = 1'b0;

    repeat (5) step(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    check("nop dq_oe_o", 32'(dq_oe_o), 32'h0);
    check("nop err_code_o", 32'(err_code_o), 32'h0);
    check("nop ref_cnt_o", 32'(ref_cnt_o), 32'h0);

    // READ before any mode register set
    step(C_RD, 2'd0, 13'h0, 2'b00, 16'h0);
    check("pre-mrs err_o", 32'(err_o), 32'h1);
    check("pre-mrs err_code_o", 32'(err_code_o), 32'h2);
    check("pre-mrs dq_oe_o", 32'(dq_oe_o), 32'h0);
    step(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    check("pre-mrs err_o drop", 32'(err_o), 32'h0);

    // CL2 BL8: auto-precharged write, closed-bank check, then read back
    add(C_MRS, 2'd0, 13'h023, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h2);
    add(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h2);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h2);
    add(C_WR,  2'd1, 13'h400, 2'b00, 16'h1000, 1'b0, 16'h0, 1'b0, 4'h2);
    for (int k = 1; k < 8; k++)
      add(C_NOP, 2'd0, 13'h0, 2'b00, 16'h1000 + 16'(k), 1'b0, 16'h0, 1'b0, 4'h2);
    add(C_RD,  2'd1, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b1, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_RD,  2'd1, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    for (int k = 0; k < 8; k++)
      add(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b1, 16'h1000 + 16'(k), 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    run_vecs("bl8");

    // CL3 BL4: write from col 5 wraps 5,6,7,4; read from col 4 gives D,A,B,C
    add(C_MRS, 2'd0, 13'h032, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_WR,  2'd1, 13'h005, 2'b00, 16'h000A, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h000B, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h000C, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h000D, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_RD,  2'd1, 13'h004, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h000D, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h000A, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h000B, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h000C, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    run_vecs("bl4");

    // CL2 BL1: upper byte masked on the second write keeps 8'hFF
    add(C_MRS, 2'd0, 13'h020, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_WR,  2'd1, 13'h010, 2'b00, 16'hFFFF, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_WR,  2'd1, 13'h010, 2'b10, 16'h1234, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_RD,  2'd1, 13'h010, 2'b11, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'hFF34, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    // Closed bank 2 read, ACT on open bank, PRE-all then read closed bank 1
    add(C_RD,  2'd2, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b1, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h3);
    add(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0, 1'b0, 16'h0, 1'b1, 4'h7);
    add(C_ACT, 2'd2, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h7);
    add(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h7);
    add(C_RD,  2'd1, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b1, 4'h7);
    add(C_RD,  2'd2, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b1, 4'h7);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h7);
    run_vecs("mask");

    // Refresh counter wraps after 65536 REFs
    for (int i = 0; i < 65535; i++) step(C_REF, 2'd0, 13'h0, 2'b00, 16'h0);
    check("ref_cnt 65535", 32'(ref_cnt_o), 32'hFFFF);
    step(C_REF, 2'd0, 13'h0, 2'b00, 16'h0);
    check("ref_cnt wrap", 32'(ref_cnt_o), 32'h0);
    repeat (8) step(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0);

    // Reset in the middle of a BL8 read
    code_after_ref = TCHK ? 4'hF : 4'h7;
    add(C_MRS, 2'd0, 13'h023, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, code_after_ref);
    add(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, code_after_ref);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, code_after_ref);
    add(C_RD,  2'd1, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, code_after_ref);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, code_after_ref);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h1000, 1'b0, code_after_ref);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h1001, 1'b0, code_after_ref);
    run_vecs("midrst");
    rst_i = 1'b1;
    #1;
    check("midrst dq_oe_o", 32'(dq_oe_o), 32'h0);
    check("midrst dq_o", 32'(dq_o), 32'h0);
    check("midrst err_code_o", 32'(err_code_o), 32'h0);
    check("midrst ref_cnt_o", 32'(ref_cnt_o), 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // RAM survives reset; READ one cycle after ACT trips tRCD only with checking built in
    add(C_MRS, 2'd0, 13'h020, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h0);
    add(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 4'h0);
    add(C_RD,  2'd1, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, TCHK, TCHK ? 4'h8 : 4'h0);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, TCHK ? 4'h8 : 4'h0);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h1000, 1'b0, TCHK ? 4'h8 : 4'h0);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, TCHK ? 4'h8 : 4'h0);
    run_vecs("trcd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
